pri_encoder_arb: RTL and testbench
==================================

# pri_encoder_arb

Registered N-to-log2(N) priority encoder with request capture and a valid/ready output stage. It is the encoding end of the decoder path: single-cycle request pulses on `req_i` are latched into a pending register. The highest-priority pending line is encoded into `code_o` and held until the downstream consumer accepts it. It typically feeds a decoder or an interrupt/event handler that expects one binary index at a time.

## Interface
- `N`, default 4: number of request lines; legal range 2..16.
- `W`, localparam = $clog2(N): code width (2 for N=4).

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `req_i`, input, N: request pulses; a bit high for one cycle is one event.
- `ready_i`, input, 1: consumer accepts `code_o` when `valid_o && ready_i`.
- `code_o`, output, W: binary index of the selected request.
- `valid_o`, output, 1: `code_o` holds an unconsumed event.
- `pending_o`, output, N: current pending register (events not yet loaded into the output stage).
- `overflow_o`, output, 1: one-cycle pulse when an event is lost.

## Operation
- Pending register `pend` (N bits). Output stage registers: `code_o`, `valid_o`.
- The output stage is free in a cycle when `!valid_o || ready_i`.
- Load: when the output stage is free and `pend != 0`:
  - select bit `s` from registered `pend` (priority rule below);
  - next `code_o = s`, next `valid_o = 1`;
  - `load_mask = 1<<s`.
  - Otherwise `load_mask = 0`.
- When the output stage is free and `pend == 0`, next `valid_o = 0`. `code_o` keeps its last value.
- Pending update: `pend_next = (pend & ~load_mask) | req_i`.
- Selection reads only the registered `pend`. A request arriving this cycle is never loaded in the same cycle.
- Overflow: `overflow_o_next = |(req_i & pend & ~load_mask)`. The new event merges into the existing pending bit and one event is lost.
- A request on a bit that is being loaded in the same cycle is not overflow. The bit is cleared and set again, leaving one new pending event.
- A request on a bit currently held in the output stage is not overflow. It becomes a new pending event.
- `ready_i` while `valid_o == 0` is ignored.
- While `valid_o && !ready_i`, `code_o` is stable and `pend` only gains bits.

## Timing
- Reset, on the first `clk` edge with `rst == 1`:
  - `pend = 0`, `code_o = 0`, `valid_o = 0`, `overflow_o = 0`;
  - RR pointer `last = N-1`.
- `rst` has priority over all other activity. Reset mid-handshake drops the held code and all pending events without an overflow pulse.
- Latency, with the output stage idle: `req_i` high before edge k sets `pend` at edge k. `valid_o`/`code_o` are updated at edge k+1. Total is 2 cycles.
- Throughput: one code per cycle while `ready_i` is held high and `pend != 0`.
- Back-to-back: on an accept edge with `pend != 0`, the next code replaces the accepted one on that same edge. `valid_o` stays high.
- `overflow_o` is asserted for exactly one cycle, one edge after the losing `req_i`.
- `pending_o` is the registered `pend`, with no combinational path from `req_i`.

## Configuration
- Macro `PRI_ENC_ROUND_ROBIN_EN`.
- Undefined (fixed priority):
  - the highest set index in `pend` wins, so bit N-1 has top priority;
  - the `last` register is not instantiated.
- Defined (round-robin):
  - the search starts at `(last+1) mod N` and proceeds upward with wrap-around; the first set bit wins;
  - `last` updates to `s` on every load;
  - after reset the first search starts at bit 0.
- All ports and timing are identical in both builds.

## Test plan
- Reset and idle: assert `rst` for 2 cycles, then `req_i = 0`.
  - Required: `valid_o = 0`, `code_o = 00`, `pending_o = 0000`, `overflow_o = 0` on every cycle.
- Single event: pulse `req_i = 0100`, `ready_i = 1`.
  - Required: `pending_o = 0100` after edge 1; `valid_o = 1`, `code_o = 10` after edge 2.
  - Required: `valid_o = 0`, `pending_o = 0000` after edge 3.
- Priority (fixed build): pulse `req_i = 1011`, `ready_i = 1`.
  - Required: codes `11`, `01`, `00` on three consecutive cycles with `valid_o` high throughout.
  - Round-robin build, same stimulus: codes `00`, `01`, `11`.
- Backpressure: `ready_i = 0`, pulse `req_i = 0001`, then `req_i = 0010` two cycles later.
  - Required: `code_o = 00` with `valid_o = 1` held stable; `pending_o = 0010`.
  - Then raise `ready_i`. Required: `code_o = 01` on the accept edge, then `valid_o = 0`.
- Overflow: with `ready_i = 0` and `valid_o = 1` holding code `00`, pulse `req_i = 0010` twice, 2 cycles apart.
  - Required: exactly one `overflow_o` pulse, one cycle after the second pulse; `pending_o` stays `0010`.
- Reset mid-operation: `valid_o = 1`, `pending_o = 1100`, assert `rst`.
  - Required: all outputs at reset values after the edge, no `overflow_o` pulse, no code for the dropped events after `rst` deasserts.

Source files
------------

// File: rtl/pri_encoder_arb.sv
// pri_encoder_arb: registered N-to-log2(N) priority encoder with pending-event capture and a valid/ready output stage.
// Define PRI_ENC_ROUND_ROBIN_EN for round-robin selection; the default build uses fixed priority (bit N-1 highest).
module pri_encoder_arb #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_i,
   input  logic                 ready_i,
   output logic [$clog2(N)-1:0] code_o,
   output logic                 valid_o,
   output logic [N-1:0]         pending_o,
   output logic                 overflow_o
);
   localparam int W = $clog2(N);
   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] pend_r;
   logic [W-1:0] code_r;
   logic         valid_r;
   logic         overflow_r;

   logic         free_s;
   logic         found_s;
   logic         load_s;
   logic [W-1:0] sel_s;
   logic [N-1:0] load_mask_s;

   // Fixed priority: the highest set index wins.
   function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] p);
      logic [W-1:0] s;
      s = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         s = p[i] ? W'(i) : s;
      end
      return s;
   endfunction

   // Round-robin: lowest set index above last, otherwise wrap to the lowest set index overall.
   function automatic logic [W-1:0] pick_rr(input logic [N-1:0] p, input logic [W-1:0] last);
      logic [W-1:0] s_hi;
      logic [W-1:0] s_lo;
      logic         f_hi;
      s_hi = {W{1'b0}};
      s_lo = {W{1'b0}};
      f_hi = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         s_lo = p[i] ? W'(i) : s_lo;
         s_hi = (p[i] && (W'(i) > last)) ? W'(i) : s_hi;
         f_hi = f_hi | (p[i] && (W'(i) > last));
      end
      return f_hi ? s_hi : s_lo;
   endfunction

   assign free_s      = !valid_r || ready_i;
   assign found_s     = |pend_r;
   assign load_s      = free_s && found_s;
   assign load_mask_s = load_s ? (ONE_N << sel_s) : {N{1'b0}};

`ifdef PRI_ENC_ROUND_ROBIN_EN
   logic [W-1:0] last_r;

   assign sel_s = pick_rr(pend_r, last_r);

   // Round-robin pointer remembers the most recently loaded line.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r <= W'(N - 1);
      end else if (load_s) begin
         last_r <= sel_s;
      end else begin
         last_r <= last_r;
      end
   end
`else
   assign sel_s = pick_fixed(pend_r);
`endif

   // Pending capture, output stage and overflow flag; selection only ever sees the registered pend_r.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r     <= {N{1'b0}};
         code_r     <= {W{1'b0}};
         valid_r    <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         pend_r     <= (pend_r & ~load_mask_s) | req_i;
         overflow_r <= |(req_i & pend_r & ~load_mask_s);
         if (load_s) begin
            valid_r <= 1'b1;
            code_r  <= sel_s;
         end else if (free_s) begin
            valid_r <= 1'b0;
            code_r  <= code_r;
         end else begin
            valid_r <= valid_r;
            code_r  <= code_r;
         end
      end
   end

   assign code_o     = code_r;
   assign valid_o    = valid_r;
   assign pending_o  = pend_r;
   assign overflow_o = overflow_r;

endmodule

// File: tb/tb_pri_encoder_arb.sv
// Self-checking bench for pri_encoder_arb (N=4): directed scenario tables plus randomized traffic
// checked against an event-level reference model.
module tb_pri_encoder_arb;
   localparam int N = 4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       ready;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit [3:0] m_pend;
   int       m_code;
   bit       m_valid;
   bit       m_ovf;
   int       m_last;

   pri_encoder_arb #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req),
      .ready_i    (ready),
      .code_o     (code),
      .valid_o    (valid),
      .pending_o  (pending),
      .overflow_o (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge, updating the reference model from the inputs applied before the edge.
   task automatic tick();
      int       s;
      bit [3:0] mask;
      s = -1;
      if ((!m_valid || ready) && m_pend != 4'b0000) begin
`ifdef PRI_ENC_ROUND_ROBIN_EN
         for (int k = 1; k <= N; k++)
            if (s < 0 && m_pend[(m_last + k) % N]) s = (m_last + k) % N;
`else
         for (int i = N - 1; i >= 0; i--)
            if (s < 0 && m_pend[i]) s = i;
`endif
      end
      mask = (s >= 0) ? 4'(1 << s) : 4'b0000;
      @(posedge clk);
      #1;
      if (rst) begin
         m_pend = 4'b0000; m_code = 0; m_valid = 1'b0; m_ovf = 1'b0; m_last = N - 1;
      end else begin
         m_ovf  = |(req & m_pend & ~mask);
         m_pend = (m_pend & ~mask) | req;
         if (s >= 0) begin
            m_valid = 1'b1; m_code = s; m_last = s;
         end else if (!m_valid || ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Row layout: {rst, ready, req[3:0], expected {valid, code[1:0], pending[3:0], overflow}}
   task automatic test_reset();
      logic [13:0] t [4] = '{
         {1'b1, 1'b1, 4'b1111, 8'b0_00_0000_0},
         {1'b1, 1'b0, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b0, 4'b0000, 8'b0_00_0000_0}};
      logic [7:0] obs;
      for (int i = 0; i < 4; i++) begin
         {rst, ready, req} = t[i][13:8];
         tick();
         obs = {valid, code, pending, overflow};
         total++;
         if (obs !== t[i][7:0]) begin
            bad++;
            $display("FAIL reset[%0d]: got %b required %b", i, obs, t[i][7:0]);
         end
      end
   endtask

   task automatic test_single();
      logic [13:0] t [3] = '{
         {1'b0, 1'b1, 4'b0100, 8'b0_00_0100_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_10_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_10_0000_0}};
      logic [7:0] obs;
      for (int i = 0; i < 3; i++) begin
         {rst, ready, req} = t[i][13:8];
         tick();
         obs = {valid, code, pending, overflow};
         total++;
         if (obs !== t[i][7:0]) begin
            bad++;
            $display("FAIL single[%0d]: got %b required %b", i, obs, t[i][7:0]);
         end
      end
   endtask

   task automatic test_priority();
      logic [13:0] t [6] = '{
         {1'b1, 1'b1, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b1, 4'b1011, 8'b0_00_1011_0},
`ifdef PRI_ENC_ROUND_ROBIN_EN
         {1'b0, 1'b1, 4'b0000, 8'b1_00_1010_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_01_1000_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_11_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_11_0000_0}};
`else
         {1'b0, 1'b1, 4'b0000, 8'b1_11_0011_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_01_0001_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_00_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_00_0000_0}};
`endif
      logic [7:0] obs;
      for (int i = 0; i < 6; i++) begin
         {rst, ready, req} = t[i][13:8];
         tick();
         obs = {valid, code, pending, overflow};
         total++;
         if (obs !== t[i][7:0]) begin
            bad++;
            $display("FAIL priority[%0d]: got %b required %b", i, obs, t[i][7:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [13:0] t [7] = '{
         {1'b1, 1'b0, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b0, 4'b0001, 8'b0_00_0001_0},
         {1'b0, 1'b0, 4'b0000, 8'b1_00_0000_0},
         {1'b0, 1'b0, 4'b0010, 8'b1_00_0010_0},
         {1'b0, 1'b0, 4'b0000, 8'b1_00_0010_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_01_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_01_0000_0}};
      logic [7:0] obs;
      for (int i = 0; i < 7; i++) begin
         {rst, ready, req} = t[i][13:8];
         tick();
         obs = {valid, code, pending, overflow};
         total++;
         if (obs !== t[i][7:0]) begin
            bad++;
            $display("FAIL backpressure[%0d]: got %b required %b", i, obs, t[i][7:0]);
         end
      end
   endtask

   // Lost event, then re-request of a line being loaded and of the line held in the output stage.
   task automatic test_overflow();
      logic [13:0] t [15] = '{
         {1'b1, 1'b0, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b0, 4'b0001, 8'b0_00_0001_0},
         {1'b0, 1'b0, 4'b0000, 8'b1_00_0000_0},
         {1'b0, 1'b0, 4'b0010, 8'b1_00_0010_0},
         {1'b0, 1'b0, 4'b0000, 8'b1_00_0010_0},
         {1'b0, 1'b0, 4'b0010, 8'b1_00_0010_1},
         {1'b0, 1'b0, 4'b0000, 8'b1_00_0010_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_01_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_01_0000_0},
         {1'b0, 1'b1, 4'b0100, 8'b0_01_0100_0},
         {1'b0, 1'b1, 4'b0100, 8'b1_10_0100_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_10_0000_0},
         {1'b0, 1'b0, 4'b0100, 8'b1_10_0100_0},
         {1'b0, 1'b1, 4'b0000, 8'b1_10_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_10_0000_0}};
      logic [7:0] obs;
      for (int i = 0; i < 15; i++) begin
         {rst, ready, req} = t[i][13:8];
         tick();
         obs = {valid, code, pending, overflow};
         total++;
         if (obs !== t[i][7:0]) begin
            bad++;
            $display("FAIL overflow[%0d]: got %b required %b", i, obs, t[i][7:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] t [8] = '{
         {1'b1, 1'b0, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b0, 4'b0001, 8'b0_00_0001_0},
         {1'b0, 1'b0, 4'b0000, 8'b1_00_0000_0},
         {1'b0, 1'b0, 4'b1100, 8'b1_00_1100_0},
         {1'b1, 1'b0, 4'b0010, 8'b0_00_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_00_0000_0},
         {1'b0, 1'b1, 4'b0000, 8'b0_00_0000_0}};
      logic [7:0] obs;
      for (int i = 0; i < 8; i++) begin
         {rst, ready, req} = t[i][13:8];
         tick();
         obs = {valid, code, pending, overflow};
         total++;
         if (obs !== t[i][7:0]) begin
            bad++;
            $display("FAIL reset_mid[%0d]: got %b required %b", i, obs, t[i][7:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] obs;
      logic [7:0] exp;
      rst = 1'b1; req = 4'b0000; ready = 1'b0;
      tick();
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         req   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         ready = ($urandom_range(0, 3) != 0);
         tick();
         obs = {valid, code, pending, overflow};
         exp = {m_valid, 2'(m_code), m_pend, m_ovf};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL random[%0d]: got %b required %b", i, obs, exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; ready = 1'b0;
      m_pend = 4'b0000; m_code = 0; m_valid = 1'b0; m_ovf = 1'b0; m_last = N - 1;
      test_reset();
      test_single();
      test_priority();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
